// File: rtl/imem_fetch_controller_if.sv
// Fetch-side bus bundle: instruction memory port, decode handshake and execute redirect.
// The master modport is the fetch controller; the slave modport is its environment.
interface imem_fetch_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_data;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_WIDTH-1:0] inst_data;
    logic [ADDR_WIDTH-1:0] inst_pc;
    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_target;
    logic                  halted;

    modport master (
        output imem_addr, inst_valid, inst_data, inst_pc, halted,
        input  imem_data, inst_ready, redirect_valid, redirect_target
    );

    modport slave (
        input  imem_addr, inst_valid, inst_data, inst_pc, halted,
        output imem_data, inst_ready, redirect_valid, redirect_target
    );
endinterface

// File: rtl/imem_fetch_controller.sv
// Instruction fetch sequencer: PC, zero-latency memory capture stage, redirect and halt.
// Optional macro FETCH_PERF_CNT_EN adds fetch_count/stall_count performance counters.
module imem_fetch_controller #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 32,
    parameter int unsigned RESET_PC   = 1
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count,
`endif
    imem_fetch_if.master bus
);
    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] DEPTH_C    = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] RESET_PC_C = ADDR_WIDTH'(RESET_PC);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  inst_valid_q;
    logic [DATA_WIDTH-1:0] inst_data_q;
    logic [ADDR_WIDTH-1:0] inst_pc_q;
    logic                  halted_q;

    logic stage_free_s;
    logic xfer_s;
    logic pc_in_range_s;
    logic tgt_in_range_s;
    logic capture_s;

    assign stage_free_s   = !inst_valid_q || bus.inst_ready;
    assign xfer_s         = inst_valid_q && bus.inst_ready;
    assign pc_in_range_s  = (pc_q < DEPTH_C);
    assign tgt_in_range_s = (bus.redirect_target < DEPTH_C);
    assign capture_s      = (state_q == ST_RUN) && !bus.redirect_valid
                            && pc_in_range_s && stage_free_s;

    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = inst_valid_q;
    assign bus.inst_data  = inst_data_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.halted     = halted_q;

    // Fetch FSM: PC sequencing, output stage capture/hold/flush and halt tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_START;
            pc_q         <= RESET_PC_C;
            inst_valid_q <= 1'b0;
            inst_data_q  <= {DATA_WIDTH{1'b0}};
            inst_pc_q    <= {ADDR_WIDTH{1'b0}};
            halted_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_START: begin
                    if (bus.redirect_valid) begin
                        pc_q <= bus.redirect_target;
                        if (tgt_in_range_s) begin
                            state_q <= ST_RUN;
                        end else begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Redirect wins over capture and flushes even a word being accepted.
                    if (bus.redirect_valid) begin
                        pc_q         <= bus.redirect_target;
                        inst_valid_q <= 1'b0;
                        if (!tgt_in_range_s) begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                        end
                    end else if (!pc_in_range_s) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                        if (xfer_s) begin
                            inst_valid_q <= 1'b0;
                        end
                    end else if (stage_free_s) begin
                        inst_data_q  <= bus.imem_data;
                        inst_pc_q    <= pc_q;
                        inst_valid_q <= 1'b1;
                        pc_q         <= pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                    end
                end
                ST_HALT: begin
                    if (bus.redirect_valid) begin
                        pc_q         <= bus.redirect_target;
                        inst_valid_q <= 1'b0;
                        if (tgt_in_range_s) begin
                            state_q  <= ST_RUN;
                            halted_q <= 1'b0;
                        end
                    end else if (xfer_s) begin
                        inst_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_HALT;
                    halted_q     <= 1'b1;
                    inst_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Performance counters: captured words and back-pressured RUN cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (capture_s) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if ((state_q == ST_RUN) && inst_valid_q && !bus.inst_ready) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_imem_fetch_controller.sv
// Directed bench for imem_fetch_controller with a scoreboard of expected fetch addresses.
module tb_imem_fetch_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] mem [0:31];
    logic [31:0] sb_q [$];

    imem_fetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    imem_fetch_controller #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(32), .RESET_PC(1)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count(fetch_count),
        .stall_count(stall_count),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.imem_data = (bus.imem_addr < 32'd32) ? mem[bus.imem_addr[4:0]] : 32'h0000_0000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pops/compares a transfer about to happen, then advances one edge and settles.
    task automatic tick();
        logic [31:0] e;
        if (bus.inst_valid === 1'b1 && bus.inst_ready === 1'b1) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected observed pc=%0h expected no transfer", bus.inst_pc);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("xfer_pc", bus.inst_pc, e);
                chk("xfer_data", bus.inst_data, mem[e[4:0]]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) sb_q.push_back(32'(i));
    endtask

    task automatic run_until_pc(input logic [31:0] p);
        int n = 0;
        while (!(bus.inst_valid === 1'b1 && bus.inst_pc === p) && n < 100) begin
            tick();
            n++;
        end
        chk("reach_pc", bus.inst_pc, p);
    endtask

    task automatic run_until_halt();
        int n = 0;
        while (bus.halted !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        chk("reach_halt", bus.halted, 1'b1);
    endtask

    initial begin
        logic [31:0] held_data;
        for (int i = 0; i < 32; i++) mem[i] = {16'hC0DE, 16'(i * 37 + 5)};
        bus.inst_ready      = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'd0;

        // Reset values
        #13;
        chk("rst_valid", bus.inst_valid, 1'b0);
        chk("rst_halted", bus.halted, 1'b0);
        chk("rst_addr", bus.imem_addr, 32'd1);
        chk("rst_data", bus.inst_data, 32'd0);
        chk("rst_pc", bus.inst_pc, 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_fetch_cnt", fetch_count, 32'd0);
        chk("rst_stall_cnt", stall_count, 32'd0);
`endif

        // Start-up latency: bubble then first capture
        @(posedge clk); #1;
        bus.inst_ready = 1'b1;
        rst = 1'b0;
        push_range(1, 5);
        tick();
        chk("start_bubble_valid", bus.inst_valid, 1'b0);
        chk("start_addr", bus.imem_addr, 32'd1);
        tick();
        chk("first_valid", bus.inst_valid, 1'b1);
        chk("first_pc", bus.inst_pc, 32'd1);

        // Back-pressure at inst_pc=4
        run_until_pc(32'd4);
        bus.inst_ready = 1'b0;
        held_data = bus.inst_data;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", bus.inst_pc, 32'd4);
            chk("stall_data", bus.inst_data, held_data);
            chk("stall_valid", bus.inst_valid, 1'b1);
            chk("stall_addr", bus.imem_addr, 32'd5);
        end
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_cnt", fetch_count, 32'd4);
        chk("stall_cnt", stall_count, 32'd3);
`endif
        bus.inst_ready = 1'b1;
        tick();
        chk("resume_pc", bus.inst_pc, 32'd5);

        // Redirect to 7 while 5 is presented; 6 must never appear
        push_range(7, 31);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'd7;
        tick();
        bus.redirect_valid = 1'b0;
        chk("redir_flush_valid", bus.inst_valid, 1'b0);
        chk("redir_addr", bus.imem_addr, 32'd7);
        tick();
        chk("redir_pc", bus.inst_pc, 32'd7);

        // Free-run off the end of memory
        run_until_halt();
        chk("halt_valid", bus.inst_valid, 1'b0);
        chk("halt_addr", bus.imem_addr, 32'd32);
        chk("halt_sb_empty", sb_q.size(), 0);
        tick();
        tick();
        chk("halt_addr_frozen", bus.imem_addr, 32'd32);
        chk("halt_sticky", bus.halted, 1'b1);

        // Recover from HALT with in-range redirect
        push_range(3, 12);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'd3;
        tick();
        bus.redirect_valid = 1'b0;
        chk("unhalt", bus.halted, 1'b0);
        chk("unhalt_valid", bus.inst_valid, 1'b0);
        tick();
        chk("unhalt_pc", bus.inst_pc, 32'd3);

        // Asynchronous reset mid-stream
        run_until_pc(32'd12);
        rst = 1'b1;
        #2;
        chk("arst_valid", bus.inst_valid, 1'b0);
        chk("arst_addr", bus.imem_addr, 32'd1);
        chk("arst_halted", bus.halted, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        chk("arst_fetch_cnt", fetch_count, 32'd0);
        chk("arst_stall_cnt", stall_count, 32'd0);
`endif
        sb_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        push_range(1, 3);
        tick();
        tick();
        chk("restart_pc", bus.inst_pc, 32'd1);
        run_until_pc(32'd3);

        // Out-of-range redirects: RUN->HALT, HALT stays, then back in range
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'd40;
        tick();
        chk("oor_halted", bus.halted, 1'b1);
        chk("oor_addr", bus.imem_addr, 32'd40);
        chk("oor_valid", bus.inst_valid, 1'b0);
        bus.redirect_target = 32'd50;
        tick();
        chk("oor2_halted", bus.halted, 1'b1);
        chk("oor2_addr", bus.imem_addr, 32'd50);
        bus.redirect_target = 32'd31;
        tick();
        bus.redirect_valid = 1'b0;
        chk("last_unhalt", bus.halted, 1'b0);
        push_range(31, 31);
        tick();
        chk("last_pc", bus.inst_pc, 32'd31);
        tick();
        chk("last_halt", bus.halted, 1'b1);
        chk("last_valid", bus.inst_valid, 1'b0);
        chk("final_sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imem_fetch_controller.md
Name: imem_fetch_controller

Overview:
Sequences the word-addressed instruction memory for the RISC-V core. Holds the PC and drives the memory address. Captures the combinational read data into a registered output stage with a valid/ready handshake toward decode. Accepts branch/jump redirects from execute, and halts when the PC runs past the end of the memory.

Parameters:
ADDR_WIDTH, 32, width of PC and memory address (word index, not byte address)
DATA_WIDTH, 32, instruction width
MEM_DEPTH, 32, number of instruction words; valid PCs are 0..MEM_DEPTH-1
RESET_PC, 1, first word fetched after reset (program image starts at index 1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_addr  output  ADDR_WIDTH  word address to instruction memory; combinational copy of pc
imem_data  input  DATA_WIDTH  asynchronous read data from instruction memory
inst_valid  output  1  inst_data/inst_pc hold a fetched instruction
inst_ready  input  1  decode accepts the instruction this cycle
inst_data  output  DATA_WIDTH  registered instruction word
inst_pc  output  ADDR_WIDTH  word address inst_data was fetched from
redirect_valid  input  1  execute requests a PC change (taken branch/jump)
redirect_target  input  ADDR_WIDTH  new word address
halted  output  1  fetch stopped: PC out of range

Behaviour:
- Reset (async, any time): pc=RESET_PC, state=START, inst_valid=0, inst_data=0, inst_pc=0, halted=0.
- imem_addr = pc at all times. Memory read is zero-latency, so data is sampled on the same edge.
- States: START, RUN, HALT.
- START: one bubble cycle after reset deassertion, with no capture; then move to RUN. If redirect_valid is high here, load pc=redirect_target.
- Output stage is free when (!inst_valid || inst_ready).
- RUN, no redirect, pc<MEM_DEPTH, stage free, on a clock edge: inst_data<=imem_data, inst_pc<=pc, inst_valid<=1, pc<=pc+1. This gives one instruction per cycle sustained.
- RUN, stage not free: hold pc, inst_data, inst_pc and inst_valid stable. These must not change while valid && !ready.
- Handshake: a transfer occurs on an edge with inst_valid && inst_ready. Once asserted, inst_valid is never dropped except by redirect or reset.
- Redirect (any state except during reset) has priority over capture:
  - pc<=redirect_target and inst_valid<=0, which flushes the wrong-path instruction even if inst_ready is high.
  - No capture occurs that cycle; the next instruction is fetched on the following edge.
  - Target >= MEM_DEPTH leads to HALT on that edge.
- RUN, pc >= MEM_DEPTH (including pc+1 wrapping past the last word): no capture. Go to HALT and set halted=1. Any already-valid instruction stays until it is consumed (inst_valid clears on the transfer).
- HALT: pc frozen; halted=1.
  - Redirect with target < MEM_DEPTH: pc<=target, halted<=0, state RUN.
  - Redirect with target >= MEM_DEPTH: pc<=target, stay in HALT.
- PC arithmetic is modulo 2^ADDR_WIDTH. The range check always uses an unsigned compare against MEM_DEPTH.
- Simultaneous transfer and redirect: the transfer counts as consumed; the stage still ends empty.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds two output ports, fetch_count[31:0] and stall_count[31:0], both reset to 0.
  - fetch_count increments on each capture edge.
  - stall_count increments on each RUN edge where inst_valid && !inst_ready.
  - Both counters wrap at 2^32 and are frozen in HALT.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then inst_ready=1 held, memory words 1..10 loaded -> first inst_valid 2 cycles after rst falls with inst_pc=1. inst_pc then steps 2,3,...,10 on consecutive cycles with inst_data equal to mem[inst_pc].
- inst_ready=0 for 3 cycles while inst_pc=4 -> inst_data/inst_pc/inst_valid constant for those 3 cycles. imem_addr stays 5. After ready returns, inst_pc goes 5, 6 with no word skipped or duplicated.
- redirect_valid=1 with target=7 while inst_pc=5 is valid -> next cycle inst_valid=0. Following cycle inst_pc=7. The word at 6 is never presented.
- Free-run to the end with MEM_DEPTH=32 -> inst_pc=31 delivered, then halted=1, inst_valid=0 after the transfer, and imem_addr stays 32. Redirect target=3 -> halted=0 and inst_pc=3 two cycles later.
- rst asserted mid-stream at inst_pc=12 -> inst_valid=0 and pc=1 immediately, without waiting for a clock edge. After release the sequence restarts from 1.
- FETCH_PERF_CNT_EN defined, 10 fetches with 3 stall cycles -> fetch_count=10, stall_count=3. Reset returns both counters to 0.
